// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit : ID-stage forwarding select, load-use stall, stall counter
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic [4:0]       Rd_EX,
  input  logic [4:0]       Rd_MEM,
  input  logic [4:0]       Rd_WB,
  input  logic             RegWrite_EX,
  input  logic             RegWrite_MEM,
  input  logic             RegWrite_WB,
  input  logic             MemRead_EX,
  input  logic             RPzero_EX,
  input  logic             RPzero_MEM,
  input  logic             RPzero_WB,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] c_sel_rf  = 2'b00;
  localparam logic [1:0] c_sel_ex  = 2'b01;
  localparam logic [1:0] c_sel_mem = 2'b10;
  localparam logic [1:0] c_sel_wb  = 2'b11;
  localparam logic [4:0] c_r30     = 5'd30;

  logic w_valid_ex;
  logic w_valid_mem;
  logic w_valid_wb;

  // R0 reads as zero and R30 writes are dropped, so neither may be forwarded.
  assign w_valid_ex  = RegWrite_EX  & ~RPzero_EX  & (Rd_EX  != 5'd0) & (Rd_EX  != c_r30);
  assign w_valid_mem = RegWrite_MEM & ~RPzero_MEM & (Rd_MEM != 5'd0) & (Rd_MEM != c_r30);
  assign w_valid_wb  = RegWrite_WB  & ~RPzero_WB  & (Rd_WB  != 5'd0) & (Rd_WB  != c_r30);

  always_comb begin
    ForwardA = c_sel_rf;
    if (w_valid_ex && (Rd_EX == Rs))
      ForwardA = c_sel_ex;
    else if (w_valid_mem && (Rd_MEM == Rs))
      ForwardA = c_sel_mem;
    else if (w_valid_wb && (Rd_WB == Rs))
      ForwardA = c_sel_wb;
  end

  always_comb begin
    ForwardB = c_sel_rf;
    if (w_valid_ex && (Rd_EX == Rt))
      ForwardB = c_sel_ex;
    else if (w_valid_mem && (Rd_MEM == Rt))
      ForwardB = c_sel_mem;
    else if (w_valid_wb && (Rd_WB == Rt))
      ForwardB = c_sel_wb;
  end

  assign Stall = MemRead_EX & w_valid_ex & ((Rd_EX == Rs) | (Rd_EX == Rt));

  logic [CNT_W-1:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_count <= '0;
    else if (Stall && (r_stall_count != {CNT_W{1'b1}}))
      r_stall_count <= r_stall_count + 1'b1;
  end

  assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit : directed vectors, queued expectations, negedge monitor
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_unit;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs, Rt, Rd_EX, Rd_MEM, Rd_WB;
  logic             RegWrite_EX, RegWrite_MEM, RegWrite_WB;
  logic             MemRead_EX;
  logic             RPzero_EX, RPzero_MEM, RPzero_WB;
  logic [1:0]       ForwardA, ForwardB;
  logic             Stall;
  logic [CNT_W-1:0] stall_count;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs(Rs), .Rt(Rt), .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
    .MemRead_EX(MemRead_EX),
    .RPzero_EX(RPzero_EX), .RPzero_MEM(RPzero_MEM), .RPzero_WB(RPzero_WB),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             st;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  exp_t             exp_q[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  logic             prev_rst = 1'b1;
  logic             prev_st  = 1'b0;
  bit               drv_done = 1'b0;

  // rw / rp bit order: {EX, MEM, WB}
  task automatic step(input string name,
                      input logic [4:0] rs_v, input logic [4:0] rt_v,
                      input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
                      input logic [2:0] rw, input logic mr, input logic [2:0] rp,
                      input logic rst_v,
                      input logic [1:0] efa, input logic [1:0] efb, input logic est);
    exp_t e;
    @(posedge clk);
    if (prev_rst)
      model_cnt = '0;
    else if (prev_st && model_cnt != CNT_MAX)
      model_cnt = model_cnt + 1'b1;
    #1;
    Rs = rs_v; Rt = rt_v; Rd_EX = rde; Rd_MEM = rdm; Rd_WB = rdw;
    {RegWrite_EX, RegWrite_MEM, RegWrite_WB} = rw;
    MemRead_EX = mr;
    {RPzero_EX, RPzero_MEM, RPzero_WB} = rp;
    reset = rst_v;
    prev_rst = rst_v;
    prev_st  = est;
    e.fa = efa; e.fb = efb; e.st = est; e.cnt = model_cnt; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; Rs = '0; Rt = '0; Rd_EX = '0; Rd_MEM = '0; Rd_WB = '0;
    RegWrite_EX = 0; RegWrite_MEM = 0; RegWrite_WB = 0; MemRead_EX = 0;
    RPzero_EX = 0; RPzero_MEM = 0; RPzero_WB = 0;

    //   name          rs  rt  rde rdm rdw  rw      mr  rp      rst  fa     fb     st
    step("reset",      0,  0,  0,  0,  0,  3'b000, 0, 3'b000, 1, 2'b00, 2'b00, 0);
    step("idle",       0,  0,  0,  0,  0,  3'b000, 0, 3'b000, 0, 2'b00, 2'b00, 0);
    step("fwd_ex",     3,  0,  3,  0,  0,  3'b100, 0, 3'b000, 0, 2'b01, 2'b00, 0);
    step("prio_ex",    5,  5,  5,  5,  5,  3'b111, 0, 3'b000, 0, 2'b01, 2'b01, 0);
    step("sq_ex_mem",  5,  5,  5,  5,  5,  3'b111, 0, 3'b100, 0, 2'b10, 2'b10, 0);
    step("sq_ex_mem2", 5,  5,  5,  5,  5,  3'b111, 0, 3'b110, 0, 2'b11, 2'b11, 0);
    step("sq_all",     5,  5,  5,  5,  5,  3'b111, 0, 3'b111, 0, 2'b00, 2'b00, 0);
    step("mem_gt_wb",  9,  1,  4,  9,  9,  3'b011, 0, 3'b000, 0, 2'b10, 2'b00, 0);
    step("fwd_wb",     1,  7,  4,  6,  7,  3'b111, 0, 3'b000, 0, 2'b00, 2'b11, 0);
    step("wb_r0",      0,  0,  4,  6,  0,  3'b111, 0, 3'b000, 0, 2'b00, 2'b00, 0);
    step("wb_r30",     1,  30, 4,  6,  30, 3'b111, 0, 3'b000, 0, 2'b00, 2'b00, 0);
    step("ld_r30",     30, 1,  30, 0,  0,  3'b100, 1, 3'b000, 0, 2'b00, 2'b00, 0);
    step("stall_rs1",  2,  0,  2,  0,  0,  3'b100, 1, 3'b000, 0, 2'b01, 2'b00, 1);
    step("stall_rs2",  2,  0,  2,  0,  0,  3'b100, 1, 3'b000, 0, 2'b01, 2'b00, 1);
    step("stall_rt",   8,  2,  2,  0,  0,  3'b100, 1, 3'b000, 0, 2'b00, 2'b01, 1);
    step("ld_squash",  2,  0,  2,  0,  0,  3'b100, 1, 3'b100, 0, 2'b00, 2'b00, 0);
    step("ld_in_mem",  2,  0,  9,  2,  0,  3'b010, 0, 3'b000, 0, 2'b10, 2'b00, 0);
    step("ld_nowrite", 2,  0,  2,  0,  0,  3'b000, 1, 3'b000, 0, 2'b00, 2'b00, 0);
    step("no_write",   5,  5,  5,  5,  5,  3'b000, 1, 3'b000, 0, 2'b00, 2'b00, 0);
    step("rst_stall",  2,  0,  2,  0,  0,  3'b100, 1, 3'b000, 1, 2'b01, 2'b00, 1);
    step("after_rst",  0,  0,  0,  0,  0,  3'b000, 0, 3'b000, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++)
      step("sat",      2,  2,  2,  0,  0,  3'b100, 1, 3'b000, 0, 2'b01, 2'b01, 1);
    step("sat_hold",   0,  0,  0,  0,  0,  3'b000, 0, 3'b000, 0, 2'b00, 2'b00, 0);
    step("rst_final",  0,  0,  0,  0,  0,  3'b000, 0, 3'b000, 1, 2'b00, 2'b00, 0);
    step("cleared",    0,  0,  0,  0,  0,  3'b000, 0, 3'b000, 0, 2'b00, 2'b00, 0);
    drv_done = 1'b1;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ForwardA !== e.fa) begin
          errors++;
          $display("FAIL %s ForwardA: got %b expected %b", e.name, ForwardA, e.fa);
        end
        checks++;
        if (ForwardB !== e.fb) begin
          errors++;
          $display("FAIL %s ForwardB: got %b expected %b", e.name, ForwardB, e.fb);
        end
        checks++;
        if (Stall !== e.st) begin
          errors++;
          $display("FAIL %s Stall: got %b expected %b", e.name, Stall, e.st);
        end
        checks++;
        if (stall_count !== e.cnt) begin
          errors++;
          $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.cnt);
        end
      end
    end
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!(drv_done && exp_q.size() == 0) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 5000) begin
      errors++;
      checks++;
      $display("FAIL timeout: queue depth %0d expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
